// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if: client request bus plus downstream DRAM command bus.
// Ports: i_req/i_we/i_addr/i_wdata in, o_gnt/o_done/o_err/o_rdata out, o_mem_*/i_mem_*, o_busy/o_owner.
interface dram_port_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]            i_req;
  logic [NUM_MASTERS-1:0]            i_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] i_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] i_wdata;
  logic [NUM_MASTERS-1:0]            o_gnt;
  logic [NUM_MASTERS-1:0]            o_done;
  logic                              o_err;
  logic [DATA_WIDTH-1:0]             o_rdata;
  logic                              o_mem_req;
  logic                              o_mem_we;
  logic [ADDR_WIDTH-1:0]             o_mem_addr;
  logic [DATA_WIDTH-1:0]             o_mem_wdata;
  logic                              i_mem_ready;
  logic                              i_mem_valid;
  logic [DATA_WIDTH-1:0]             i_mem_rdata;
  logic                              o_busy;
  logic [OW-1:0]                     o_owner;

  modport master (
    input  i_req, i_we, i_addr, i_wdata,
    input  i_mem_ready, i_mem_valid, i_mem_rdata,
    output o_gnt, o_done, o_err, o_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_busy, o_owner
  );

  modport slave (
    output i_req, i_we, i_addr, i_wdata,
    output i_mem_ready, i_mem_valid, i_mem_rdata,
    input  o_gnt, o_done, o_err, o_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sequencer sharing one DRAM port among NUM_MASTERS clients.
// Ports: clk, rst_n (async, active-low), bus (dram_port_arbiter_if.master). Watchdog: DRAM_ARB_WATCHDOG_EN.
module dram_port_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dram_port_arbiter_if.master  bus
);
  localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [OW-1:0] LAST_RST = OW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE = 1;

  if (NUM_MASTERS < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("dram_port_arbiter: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t                 r_state;
  logic [OW-1:0]          r_last;
  logic [NUM_MASTERS-1:0] r_gnt;
  logic [NUM_MASTERS-1:0] r_done;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_mem_addr;
  logic [DATA_WIDTH-1:0]  r_mem_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [OW-1:0]          w_win;
  logic                   w_tmo;

  // First requester strictly after the last winner, wrapping around.
  function automatic logic [OW-1:0] rr_pick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [OW-1:0]          last
  );
    logic [OW-1:0] pick;
    logic          found;
    int            idx;
    pick  = last;
    found = 1'b0;
    for (int d = 1; d <= NUM_MASTERS; d++) begin
      idx = (int'(last) + d) % NUM_MASTERS;
      if (!found && req[idx[OW-1:0]]) begin
        found = 1'b1;
        pick  = idx[OW-1:0];
      end
    end
    return pick;
  endfunction

  assign w_win = rr_pick(bus.i_req, r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= LAST_RST;
      r_gnt       <= '0;
      r_done      <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      if (w_tmo) begin
        // Watchdog abort: complete with error, no read data.
        r_state     <= IDLE;
        r_done      <= ONE << r_last;
        r_rdata     <= '0;
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (|bus.i_req) begin
              r_state     <= ISSUE;
              r_last      <= w_win;
              r_gnt       <= ONE << w_win;
              r_mem_req   <= 1'b1;
              r_mem_we    <= bus.i_we[w_win];
              r_we        <= bus.i_we[w_win];
              r_mem_addr  <= bus.i_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
              r_mem_wdata <= bus.i_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
            end
          end
          ISSUE: begin
            if (bus.i_mem_ready) begin
              r_state     <= WAIT;
              r_mem_req   <= 1'b0;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= '0;
              r_mem_wdata <= '0;
            end
          end
          WAIT: begin
            if (bus.i_mem_valid) begin
              r_state <= IDLE;
              r_done  <= ONE << r_last;
              if (!r_we) r_rdata <= bus.i_mem_rdata;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef DRAM_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_wd;
  logic          r_err;

  // Zero while idle, so it starts at 0 on the first ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo;
      if (r_state == IDLE || w_tmo) r_wd <= '0;
      else r_wd <= r_wd + 1'b1;
    end
  end

  assign w_tmo = (r_state != IDLE) &&
                 (r_wd == CW'(TIMEOUT - 1));
  assign bus.o_err = r_err;
`else
  assign w_tmo     = 1'b0;
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_gnt       = r_gnt;
  assign bus.o_done      = r_done;
  assign bus.o_rdata     = r_rdata;
  assign bus.o_mem_req   = r_mem_req;
  assign bus.o_mem_we    = r_mem_we;
  assign bus.o_mem_addr  = r_mem_addr;
  assign bus.o_mem_wdata = r_mem_wdata;
  assign bus.o_busy      = (r_state != IDLE);
  assign bus.o_owner     = r_last;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed plus random checks of dram_port_arbiter.
// Transaction-level reference model; build with DRAM_ARB_WATCHDOG_EN for watchdog checks.
module tb_dram_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef DRAM_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dram_port_arbiter_if #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) bus ();

  dram_port_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction at a time.
  bit               m_act;
  bit               m_acc;
  int               m_age;
  int               m_last;
  bit               m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wd;
  logic [DW-1:0]    m_rdata;
  logic [N-1:0]     e_gnt;
  logic [N-1:0]     e_done;
  bit               e_err;

  bit c_busy [N];
  int cli_p;
  int mem_mode;
  int gq[$];

  function automatic int rr_next(input logic [N-1:0] req, input int last);
    for (int d = 1; d <= N; d++)
      if (req[(last + d) % N]) return (last + d) % N;
    return last;
  endfunction

  task automatic model_reset();
    m_act = 0; m_acc = 0; m_age = 0;
    m_last = N - 1; m_we = 0;
    m_addr = '0; m_wd = '0; m_rdata = '0;
    e_gnt = '0; e_done = '0; e_err = 0;
    for (int k = 0; k < N; k++) c_busy[k] = 0;
  endtask

  task automatic model_edge();
    int w;
    e_gnt = '0; e_done = '0; e_err = 0;
    if (!m_act) begin
      if (bus.i_req != '0) begin
        w = rr_next(bus.i_req, m_last);
        m_last = w; m_act = 1; m_acc = 0; m_age = 0;
        m_we = bus.i_we[w];
        m_addr = bus.i_addr[w*AW +: AW];
        m_wd = bus.i_wdata[w*DW +: DW];
        e_gnt[w] = 1'b1;
      end
    end else if (WD && m_age == TO - 1) begin
      m_act = 0; e_done[m_last] = 1'b1;
      e_err = 1; m_rdata = '0;
    end else if (!m_acc) begin
      if (bus.i_mem_ready) m_acc = 1;
      m_age++;
    end else if (bus.i_mem_valid) begin
      m_act = 0; e_done[m_last] = 1'b1;
      if (!m_we) m_rdata = bus.i_mem_rdata;
    end else begin
      m_age++;
    end
  endtask

  task automatic compare();
    bit iss;
    iss = m_act && !m_acc;
    chk("gnt", bus.o_gnt, e_gnt);
    chk("done", bus.o_done, e_done);
    chk("err", bus.o_err, e_err);
    chk("rdata", bus.o_rdata, m_rdata);
    chk("busy", bus.o_busy, m_act);
    chk("owner", bus.o_owner, m_last);
    chk("mem_req", bus.o_mem_req, iss);
    chk("mem_we", bus.o_mem_we, iss ? m_we : 1'b0);
    chk("mem_addr", bus.o_mem_addr, iss ? m_addr : '0);
    chk("mem_wdata", bus.o_mem_wdata, iss ? m_wd : '0);
    for (int k = 0; k < N; k++)
      if (bus.o_gnt[k]) gq.push_back(k);
  endtask

  task automatic raise(input int k, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_req[k] = 1'b1;
    bus.i_we[k] = we;
    bus.i_addr[k*AW +: AW] = a;
    bus.i_wdata[k*DW +: DW] = d;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (bus.o_gnt[k]) begin
        bus.i_req[k] = 1'b0;
        c_busy[k] = 1;
      end
      if (bus.o_done[k]) c_busy[k] = 0;
      if (!bus.i_req[k] && !c_busy[k] &&
          $urandom_range(0, 99) < cli_p)
        raise(k, 1'($urandom & 1), $urandom, $urandom);
    end
    case (mem_mode)
      0: begin
        bus.i_mem_ready = ($urandom_range(0, 2) == 0);
        bus.i_mem_valid = ($urandom_range(0, 2) == 0);
        bus.i_mem_rdata = $urandom;
      end
      1: begin
        bus.i_mem_ready = 1'b1;
        bus.i_mem_valid = 1'b1;
        bus.i_mem_rdata = $urandom;
      end
      2: begin
        bus.i_mem_ready = 1'b0;
        bus.i_mem_valid = 1'b0;
      end
      3: begin
        bus.i_mem_ready = 1'b1;
        bus.i_mem_valid = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic clear_inputs();
    bus.i_req = '0; bus.i_we = '0;
    bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_mem_ready = 1'b0; bus.i_mem_valid = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    cli_p = 0;
    while ((m_act || bus.i_req != '0) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int n;
    clear_inputs();
    model_reset();
    cli_p = 0;
    mem_mode = 5;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.o_gnt, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_owner", bus.o_owner, N - 1);
    chk("rst_mem_req", bus.o_mem_req, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    rst_n = 1'b1;

    // Single read by master 1.
    gq.delete();
    raise(1, 1'b0, 32'h100, 32'h0);
    step();
    chk("rd_gnt", bus.o_gnt, 3'b010);
    chk("rd_addr", bus.o_mem_addr, 32'h100);
    step();
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'hDEADBEEF;
    step();
    chk("rd_done", bus.o_done, 3'b010);
    chk("rd_rdata", bus.o_rdata, 32'hDEADBEEF);
    chk("rd_err", bus.o_err, 0);
    bus.i_mem_valid = 1'b0;
    repeat (2) step();
    chk("rd_gnt_count", gq.size(), 1);

    // Write by master 2; fields held until ready.
    raise(2, 1'b1, 32'h2000, 32'hA5A5A5A5);
    step();
    chk("wr_gnt", bus.o_gnt, 3'b100);
    chk("wr_we", bus.o_mem_we, 1);
    repeat (2) begin
      step();
      chk("wr_hold_addr", bus.o_mem_addr, 32'h2000);
      chk("wr_hold_data", bus.o_mem_wdata, 32'hA5A5A5A5);
    end
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    chk("wr_req_drop", bus.o_mem_req, 0);
    step();
    bus.i_mem_valid = 1'b1;
    bus.i_mem_rdata = 32'h12345678;
    step();
    bus.i_mem_valid = 1'b0;
    chk("wr_done", bus.o_done, 3'b100);
    chk("wr_rdata_kept", bus.o_rdata, 32'hDEADBEEF);
    step();

    // Minimum latency and back-to-back grant.
    mem_mode = 1;
    raise(0, 1'b0, $urandom, $urandom);
    step();
    chk("lat_gnt", bus.o_gnt, 3'b001);
    raise(1, 1'b1, $urandom, $urandom);
    step();
    step();
    chk("lat_done", bus.o_done, 3'b001);
    step();
    chk("lat_next_gnt", bus.o_gnt, 3'b010);
    wait_idle();

    // Contention from reset: strict rotation.
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    for (int k = 0; k < N; k++) raise(k, 1'b0, $urandom, $urandom);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
    cli_p = 100;
    n = 0;
    while (gq.size() < 6 && n < 100) begin
      step();
      n++;
    end
    chk("rr_count", gq.size() >= 6, 1);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk("rr_order", 64'(gq[i]), 64'(i % 3));
    wait_idle();

    // Reset while waiting for the response.
    mem_mode = 3;
    raise(1, 1'b0, $urandom, $urandom);
    n = 0;
    while (!(m_act && m_acc) && n < 20) begin
      step();
      n++;
    end
    chk("rst_reach_wait", m_act && m_acc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_owner", bus.o_owner, N - 1);
    chk("arst_mem_req", bus.o_mem_req, 0);
    chk("arst_mem_addr", bus.o_mem_addr, 0);
    chk("arst_done", bus.o_done, 0);
    chk("arst_rdata", bus.o_rdata, 0);
    clear_inputs();
    model_reset();
    mem_mode = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) raise(k, 1'b0, $urandom, $urandom);
    rst_n = 1'b1;
    step();
    chk("arst_first_win", bus.o_gnt, 3'b001);
    wait_idle();

    // Stalled memory: watchdog abort, or indefinite wait.
    mem_mode = 2;
    raise(0, 1'b0, $urandom, $urandom);
    step();
`ifdef DRAM_ARB_WATCHDOG_EN
    n = 0;
    while (bus.o_done == '0 && n < 50) begin
      step();
      n++;
    end
    chk("wd_cycles", n, TO);
    chk("wd_err", bus.o_err, 1);
    chk("wd_rdata", bus.o_rdata, 0);
    chk("wd_idle", bus.o_busy, 0);
`else
    repeat (20) step();
    chk("stall_busy", bus.o_busy, 1);
    chk("stall_req", bus.o_mem_req, 1);
    mem_mode = 1;
`endif
    wait_idle();

    // Random traffic.
    mem_mode = 0;
    cli_p = 30;
    repeat (3000) step();
    mem_mode = 1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_port_arbiter.md
# dram_port_arbiter

- Round-robin arbiter and sequencer that shares the single GPU DRAM port among `NUM_MASTERS` requesters (fetch, vertex/raster, framebuffer writeback).
- Accepts one request at a time and presents it on the downstream port with a req/ready command handshake.
- Waits for the response, returns read data and a completion pulse to the owning master, then re-arbitrates.
- Sits between the GPU memory clients and the AXI4 master bridge.

## Interface
Parameters:
- `NUM_MASTERS`, 3: number of requesters (≥2)
- `ADDR_WIDTH`, 32: address width
- `DATA_WIDTH`, 32: data width
- `TIMEOUT`, 255: watchdog limit in cycles (used only with watchdog compiled in)

Ports:
- `clk`  in  1  clock; one clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `i_req`  in  NUM_MASTERS  per-master request
- `i_we`  in  NUM_MASTERS  per-master write (1) / read (0)
- `i_addr`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`
- `i_wdata`  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing
- `o_gnt`  out  NUM_MASTERS  one-hot, one-cycle pulse: request accepted and latched
- `o_done`  out  NUM_MASTERS  one-hot, one-cycle pulse: transaction complete
- `o_err`  out  1  valid with `o_done`; 1 = watchdog timeout
- `o_rdata`  out  DATA_WIDTH  read data; valid with `o_done` of a read, held until the next read completes
- `o_mem_req`, `o_mem_we`  out  1  downstream command valid / write
- `o_mem_addr`  out  ADDR_WIDTH  downstream address
- `o_mem_wdata`  out  DATA_WIDTH  downstream write data
- `i_mem_ready`  in  1  downstream command accepted (with `o_mem_req`)
- `i_mem_valid`  in  1  downstream response (read data or write ack)
- `i_mem_rdata`  in  DATA_WIDTH  downstream read data, valid with `i_mem_valid`
- `o_busy`  out  1  state ≠ IDLE
- `o_owner`  out  $clog2(NUM_MASTERS)  index of the current or last granted master

## Operation
States: IDLE, ISSUE, WAIT.

- **IDLE**
  - If `i_req` ≠ 0, select the first asserted master searching from `last+1` upward with wrap-around.
  - Latch that master's `we`, `addr` and `wdata`; set `last` and `o_owner` to the winner.
  - Pulse `o_gnt[winner]` in the next cycle; go to ISSUE.
- **ISSUE**
  - Drive `o_mem_req=1` with the latched fields; hold them stable until `i_mem_ready`.
  - On `i_mem_ready`, go to WAIT.
- **WAIT**
  - On `i_mem_valid`:
    - For a read, capture `i_mem_rdata` into `o_rdata`; a write leaves `o_rdata` unchanged.
    - Pulse `o_done[owner]` with `o_err=0`; go to IDLE.
  - `i_mem_valid` outside WAIT is ignored.

Rules and boundary conditions:
- A master must hold `i_req` and its fields until it sees `o_gnt`. It must deassert `i_req` by the cycle after `o_gnt`, unless it is posting a new request.
- Requests arriving while not in IDLE wait; they are never dropped.
- Simultaneous requests resolve in strict round-robin order.
- `last` resets to `NUM_MASTERS-1`, so master 0 wins the first contention.
- `i_mem_ready` and `i_mem_valid` in the same ISSUE cycle: go to WAIT only. The response is expected one or more cycles after acceptance.
- Reset mid-transaction: all state clears immediately and outputs go to reset values. No `o_done` is produced for the aborted transaction.

Reset values:
- State IDLE, `last`=NUM_MASTERS-1.
- `o_gnt`, `o_done`, `o_err`, `o_mem_req`, `o_mem_we`, `o_busy` = 0.
- `o_mem_addr`, `o_mem_wdata`, `o_rdata` = 0; `o_owner`=NUM_MASTERS-1.

## Timing
- `i_req` sampled at edge T → `o_gnt` and `o_mem_req` high in cycle T+1.
- Minimum request-to-`o_done` latency is 3 cycles: ready in T+1, valid in T+2, `o_done` in T+3.
- `o_done` and `o_rdata` are registered. `o_mem_*` are driven from registers and are zero outside ISSUE.
- Back-to-back throughput: IDLE is visited for one cycle between transactions.

## Configuration
- `DRAM_ARB_WATCHDOG_EN` defined:
  - A counter clears on entry to ISSUE and increments every cycle in ISSUE and WAIT.
  - On reaching `TIMEOUT`:
    - `o_mem_req` drops.
    - `o_done[owner]` pulses with `o_err=1`; `o_rdata` is set to 0.
    - State returns to IDLE.
- Not defined: no counter; the arbiter waits indefinitely and `o_err` is tied 0.

## Test plan
- Single read: master 1 reads 0x100, ready after 2 cycles, `i_mem_rdata`=0xDEADBEEF. Expect `o_gnt`=3'b010 once, `o_done`=3'b010 once, `o_rdata`=0xDEADBEEF, `o_err`=0.
- Write: master 2 writes 0xA5A5A5A5 to 0x2000. Expect `o_mem_we`=1 with those exact fields held until ready, `o_done[2]`, and `o_rdata` unchanged.
- Contention: all three requests asserted from reset, each re-requesting after its done, 6 transactions. Expect grant order 0,1,2,0,1,2.
- Minimum latency: ready and valid returned at earliest. Expect `i_req` at edge T → `o_done` in cycle T+3, and the next grant 1 cycle later.
- Reset mid-op: assert `rst_n`=0 during WAIT. Expect all outputs at reset values asynchronously, and after release master 0 wins the next contention.
- Watchdog (macro on, `TIMEOUT`=8): `i_mem_ready` never asserted. Expect `o_done` with `o_err`=1 exactly 8 cycles after entering ISSUE, `o_rdata`=0, return to IDLE.
